// File: rtl/wb_stage.sv
// RV32 writeback stage: registers the retiring instruction, selects the
// writeback value, holds the pipeline on pending loads, counts retirements.
module wb_stage #(
  parameter logic [6:0] RESET_OPCODE = 7'b0000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [6:0]  mem_opcode,
  input  logic [2:0]  mem_funct3,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_pc_plus4,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_rvalid,
  output logic [6:0]  opcode_out,
  output logic [4:0]  rd_addr_out,
  output logic [31:0] rd_data_out,
  output logic        rf_we,
  output logic        stall_req,
  output logic [31:0] retire_count
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    EMPTY,
    VALID,
    WAIT_LOAD
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  opcode_q, opcode_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rf_we_q, rf_we_d;
  logic [31:0] retire_count_q, retire_count_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [1:0]  ld_a_q, ld_a_d;

  logic        xfer;
  logic        op_writes;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        ld_ok;

  assign mem_ready    = (state_q != WAIT_LOAD);
  assign stall_req    = (state_q == WAIT_LOAD);
  assign xfer         = mem_valid & mem_ready;
  assign opcode_out   = opcode_q;
  assign rd_addr_out  = rd_addr_q;
  assign rd_data_out  = rd_data_q;
  assign rf_we        = rf_we_q;
  assign retire_count = retire_count_q;

  assign op_writes = (mem_opcode != OP_BRANCH) &&
                     (mem_opcode != OP_STORE) &&
                     (mem_opcode != OP_FENCE) &&
                     (mem_opcode != OP_SYSTEM);

  always_comb begin
    ld_byte = dmem_rdata[8*ld_a_q +: 8];
    ld_half = ld_a_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_data = 32'd0;
    ld_ok   = 1'b1;
    unique case (ld_f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = dmem_rdata;
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_ok   = 1'b0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    opcode_d       = RESET_OPCODE;
    rd_addr_d      = 5'd0;
    rd_data_d      = 32'd0;
    rf_we_d        = 1'b0;
    ld_rd_d        = ld_rd_q;
    ld_f3_d        = ld_f3_q;
    ld_a_d         = ld_a_q;
    retire_count_d = retire_count_q + {31'd0, state_q == VALID};
    unique case (state_q)
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          state_d  = VALID;
          opcode_d = OP_LOAD;
          if (ld_ok && ld_rd_q != 5'd0) begin
            rf_we_d   = 1'b1;
            rd_addr_d = ld_rd_q;
            rd_data_d = ld_data;
          end
        end
      end
      default: begin
        if (!xfer) begin
          state_d = EMPTY;
        end else if (mem_opcode == OP_LOAD) begin
          state_d = WAIT_LOAD;
          ld_rd_d = mem_rd;
          ld_f3_d = mem_funct3;
          ld_a_d  = mem_alu_result[1:0];
        end else begin
          state_d  = VALID;
          opcode_d = mem_opcode;
          if (op_writes && mem_rd != 5'd0) begin
            rf_we_d   = 1'b1;
            rd_addr_d = mem_rd;
            rd_data_d = (mem_opcode == OP_JAL || mem_opcode == OP_JALR)
                        ? mem_pc_plus4 : mem_alu_result;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= EMPTY;
      opcode_q       <= RESET_OPCODE;
      rd_addr_q      <= 5'd0;
      rd_data_q      <= 32'd0;
      rf_we_q        <= 1'b0;
      retire_count_q <= 32'd0;
      ld_rd_q        <= 5'd0;
      ld_f3_q        <= 3'd0;
      ld_a_q         <= 2'd0;
    end else begin
      state_q        <= state_d;
      opcode_q       <= opcode_d;
      rd_addr_q      <= rd_addr_d;
      rd_data_q      <= rd_data_d;
      rf_we_q        <= rf_we_d;
      retire_count_q <= retire_count_d;
      ld_rd_q        <= ld_rd_d;
      ld_f3_q        <= ld_f3_d;
      ld_a_q         <= ld_a_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed vector bench for wb_stage.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_wb_stage;

  localparam logic [6:0] LOAD = 7'b0000011;
  localparam logic [6:0] OPI  = 7'b0010011;
  localparam logic [6:0] OP   = 7'b0110011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] ST   = 7'b0100011;
  localparam logic [6:0] RSTO = 7'b0000000;
  localparam logic [31:0] RDATA = 32'h8081F2F3;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        mem_ready;
  logic [6:0]  mem_opcode;
  logic [2:0]  mem_funct3;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_pc_plus4;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic [6:0]  opcode_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_data_out;
  logic        rf_we;
  logic        stall_req;
  logic [31:0] retire_count;

  int vectors = 0;
  int miscompares = 0;

  wb_stage #(.RESET_OPCODE(RSTO)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_opcode(mem_opcode), .mem_funct3(mem_funct3),
    .mem_rd(mem_rd), .mem_alu_result(mem_alu_result),
    .mem_pc_plus4(mem_pc_plus4),
    .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid),
    .opcode_out(opcode_out), .rd_addr_out(rd_addr_out),
    .rd_data_out(rd_data_out), .rf_we(rf_we),
    .stall_req(stall_req), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic        rv;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [6:0]  e_op;
    logic        e_stall;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic v, logic [6:0] op, logic [2:0] f3, logic [4:0] rd,
    logic [31:0] alu, logic rv, logic e_we, logic [4:0] e_rd,
    logic [31:0] e_data, logic [6:0] e_op, logic e_stall,
    logic [31:0] e_cnt);
    vec_t r;
    r.v = v; r.op = op; r.f3 = f3; r.rd = rd; r.alu = alu; r.rv = rv;
    r.e_we = e_we; r.e_rd = e_rd; r.e_data = e_data; r.e_op = e_op;
    r.e_stall = e_stall; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic drive(logic v, logic [6:0] op, logic [2:0] f3,
                       logic [4:0] rd, logic [31:0] alu, logic rv);
    mem_valid = v; mem_opcode = op; mem_funct3 = f3;
    mem_rd = rd; mem_alu_result = alu; dmem_rvalid = rv;
  endtask

  task automatic chk(string nm, logic we, logic [4:0] rd,
                     logic [31:0] data, logic [6:0] op, logic stall,
                     logic cnt_en, logic [31:0] cnt);
    vectors++;
    if (rf_we !== we) begin
      miscompares++;
      $display("FAIL %s rf_we got %b want %b", nm, rf_we, we);
    end
    if (rd_addr_out !== rd) begin
      miscompares++;
      $display("FAIL %s rd_addr got %0d want %0d", nm, rd_addr_out, rd);
    end
    if (rd_data_out !== data) begin
      miscompares++;
      $display("FAIL %s rd_data got %h want %h", nm, rd_data_out, data);
    end
    if (opcode_out !== op) begin
      miscompares++;
      $display("FAIL %s opcode got %b want %b", nm, opcode_out, op);
    end
    if (stall_req !== stall || mem_ready !== !stall) begin
      miscompares++;
      $display("FAIL %s stall/ready got %b/%b want %b/%b",
               nm, stall_req, mem_ready, stall, !stall);
    end
    if (cnt_en && retire_count !== cnt) begin
      miscompares++;
      $display("FAIL %s retire_count got %h want %h",
               nm, retire_count, cnt);
    end
  endtask

  initial begin
    dmem_rdata = RDATA;
    mem_pc_plus4 = 32'h104;
    rst = 1'b1;
    drive(1'b1, OPI, 3'd0, 5'd5, 32'h11, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset", 1'b0, 5'd0, 32'd0, RSTO, 1'b0, 1'b1, 32'd0);
    end
    rst = 1'b0;
    drive(1'b0, OPI, 3'd0, 5'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("post_reset", 1'b0, 5'd0, 32'd0, RSTO, 1'b0, 1'b1, 32'd0);

    tbl.push_back(mk(1, OPI,  3'd0, 5'd5,  32'h11,       0, 1, 5'd5,  32'h11,       OPI,  0, 0));
    tbl.push_back(mk(1, OP,   3'd0, 5'd6,  32'h22,       0, 1, 5'd6,  32'h22,       OP,   0, 1));
    tbl.push_back(mk(1, JAL,  3'd0, 5'd1,  32'h999,      0, 1, 5'd1,  32'h104,      JAL,  0, 2));
    tbl.push_back(mk(1, BR,   3'd0, 5'd7,  32'h5,        0, 0, 5'd0,  32'h0,        BR,   0, 3));
    tbl.push_back(mk(0, OPI,  3'd0, 5'd0,  32'h0,        0, 0, 5'd0,  32'h0,        RSTO, 0, 4));
    tbl.push_back(mk(1, LOAD, 3'd4, 5'd9,  32'h1003,     1, 0, 5'd0,  32'h0,        RSTO, 1, 4));
    tbl.push_back(mk(0, OPI,  3'd0, 5'd0,  32'h0,        1, 1, 5'd9,  32'h80,       LOAD, 0, 4));
    tbl.push_back(mk(1, LOAD, 3'd1, 5'd10, 32'h2,        0, 0, 5'd0,  32'h0,        RSTO, 1, 5));
    tbl.push_back(mk(0, OPI,  3'd0, 5'd0,  32'h0,        1, 1, 5'd10, 32'hFFFF8081, LOAD, 0, 5));
    tbl.push_back(mk(1, LOAD, 3'd5, 5'd11, 32'h0,        0, 0, 5'd0,  32'h0,        RSTO, 1, 6));
    tbl.push_back(mk(0, OPI,  3'd0, 5'd0,  32'h0,        1, 1, 5'd11, 32'hF2F3,     LOAD, 0, 6));
    tbl.push_back(mk(1, LOAD, 3'd2, 5'd12, 32'h7,        0, 0, 5'd0,  32'h0,        RSTO, 1, 7));
    tbl.push_back(mk(0, OPI,  3'd0, 5'd0,  32'h0,        1, 1, 5'd12, RDATA,        LOAD, 0, 7));
    tbl.push_back(mk(1, LOAD, 3'd2, 5'd0,  32'h0,        0, 0, 5'd0,  32'h0,        RSTO, 1, 8));
    tbl.push_back(mk(0, OPI,  3'd0, 5'd0,  32'h0,        1, 0, 5'd0,  32'h0,        LOAD, 0, 8));
    tbl.push_back(mk(1, LOAD, 3'd3, 5'd13, 32'h0,        0, 0, 5'd0,  32'h0,        RSTO, 1, 9));
    tbl.push_back(mk(0, OPI,  3'd0, 5'd0,  32'h0,        1, 0, 5'd0,  32'h0,        LOAD, 0, 9));
    tbl.push_back(mk(1, LUI,  3'd0, 5'd14, 32'hABCDE000, 0, 1, 5'd14, 32'hABCDE000, LUI,  0, 10));
    tbl.push_back(mk(1, ST,   3'd2, 5'd3,  32'h40,       0, 0, 5'd0,  32'h0,        ST,   0, 11));
    tbl.push_back(mk(0, OPI,  3'd0, 5'd0,  32'h0,        0, 0, 5'd0,  32'h0,        RSTO, 0, 12));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].f3, tbl[i].rd,
            tbl[i].alu, tbl[i].rv);
      @(negedge clk);
      chk($sformatf("vec%0d", i), tbl[i].e_we, tbl[i].e_rd,
          tbl[i].e_data, tbl[i].e_op, tbl[i].e_stall, 1'b1,
          tbl[i].e_cnt);
    end

    // LB with data arriving in the third WAIT_LOAD cycle
    drive(1'b1, LOAD, 3'd0, 5'd8, 32'h102, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("lb_wait%0d", k), 1'b0, 5'd0, 32'd0, RSTO,
          1'b1, 1'b0, 32'd0);
      drive(1'b1, OPI, 3'd0, 5'd4, 32'h55, k == 2);
    end
    @(negedge clk);
    chk("lb_data", 1'b1, 5'd8, 32'hFFFFFF81, LOAD, 1'b0, 1'b1, 32'd12);
    drive(1'b0, OPI, 3'd0, 5'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("lb_empty", 1'b0, 5'd0, 32'd0, RSTO, 1'b0, 1'b1, 32'd13);

    // Reset while a load is pending discards it
    drive(1'b1, LOAD, 3'd2, 5'd15, 32'h0, 1'b0);
    @(negedge clk);
    chk("rl_wait", 1'b0, 5'd0, 32'd0, RSTO, 1'b1, 1'b1, 32'd13);
    rst = 1'b1;
    drive(1'b0, OPI, 3'd0, 5'd0, 32'd0, 1'b1);
    @(negedge clk);
    chk("rl_reset", 1'b0, 5'd0, 32'd0, RSTO, 1'b0, 1'b1, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rl_after%0d", k), 1'b0, 5'd0, 32'd0, RSTO,
          1'b0, 1'b1, 32'd0);
    end

    // Counter wrap from all-ones
    drive(1'b0, OPI, 3'd0, 5'd0, 32'd0, 1'b0);
    force dut.retire_count_q = 32'hFFFFFFFF;
    #1;
    release dut.retire_count_q;
    drive(1'b1, OPI, 3'd0, 5'd2, 32'h7, 1'b0);
    @(negedge clk);
    chk("wrap_valid", 1'b1, 5'd2, 32'h7, OPI, 1'b0, 1'b1, 32'hFFFFFFFF);
    drive(1'b0, OPI, 3'd0, 5'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("wrap_zero", 1'b0, 5'd0, 32'd0, RSTO, 1'b0, 1'b1, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
